// File: rtl/evenodd_count_checker.sv
// Receive-side monitor for the even/odd counter stream.
// Locks on the sequence, predicts the next sample and counts deviations.
module evenodd_count_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_LEN  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 mismatch,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 sticky_err
);

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_LVL = 4'(LOCK_LEN);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(2);

  state_t               state_q, state_d;
  logic [3:0]           streak_q, streak_d;
  logic                 mode_q, mode_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 mis_q, mis_d;

  logic                 par_ok;
  logic                 seq_ok;
  logic                 restart;
  logic                 err_hit;
  logic [WIDTH-1:0]     nxt;

  assign par_ok = (count[0] == mode);
  assign seq_ok = (count == exp_q) && (mode == mode_q);
  assign nxt    = count + STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACQ;
      streak_q <= '0;
      mode_q   <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    mode_d   = mode_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    mis_d    = 1'b0;
    restart  = 1'b0;
    err_hit  = 1'b0;

    if (clr_err) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end

    if (en) begin
      mode_d = mode;
      unique case (state_q)
        ACQ: begin
          if ((streak_q != 4'd0) && seq_ok) begin
            streak_d = streak_q + 4'd1;
            exp_d    = nxt;
          end else begin
            restart = 1'b1;
          end
        end
        TRACK: begin
          if (mode != mode_q) begin
            restart = 1'b1;
          end else if (count == exp_q) begin
            exp_d = nxt;
          end else begin
            err_hit = 1'b1;
            restart = 1'b1;
          end
        end
        default: restart = 1'b1;
      endcase

      // A restart re-seeds acquisition from the current sample
      if (restart) begin
        state_d = ACQ;
        if (par_ok) begin
          streak_d = 4'd1;
          exp_d    = nxt;
        end else begin
          streak_d = 4'd0;
        end
      end

      if (streak_d == LOCK_LVL)
        state_d = TRACK;

      // Clear (above) takes effect before the increment
      if (err_hit) begin
        mis_d    = 1'b1;
        sticky_d = 1'b1;
        if (cnt_d != '1)
          cnt_d = cnt_d + 1'b1;
      end
    end
  end

  assign locked     = (state_q == TRACK);
  assign mismatch   = mis_q;
  assign expected   = exp_q;
  assign err_count  = cnt_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_evenodd_count_checker.sv
// Directed bench for evenodd_count_checker.
// Second instance uses a 2-bit error counter for saturation.
module tb_evenodd_count_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [3:0] count;
  logic       clr_err;

  logic       locked, mismatch, sticky_err;
  logic [3:0] expected;
  logic [7:0] err_count;

  logic       locked2, mismatch2, sticky_err2;
  logic [3:0] expected2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  evenodd_count_checker #(
    .WIDTH(4), .ERR_CNT_W(8), .LOCK_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .count(count), .clr_err(clr_err),
    .locked(locked), .mismatch(mismatch),
    .expected(expected), .err_count(err_count),
    .sticky_err(sticky_err)
  );

  evenodd_count_checker #(
    .WIDTH(4), .ERR_CNT_W(2), .LOCK_LEN(2)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .count(count), .clr_err(clr_err),
    .locked(locked2), .mismatch(mismatch2),
    .expected(expected2), .err_count(err_count2),
    .sticky_err(sticky_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic e, input logic m,
                      input logic [3:0] c);
    en    = e;
    mode  = m;
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b0; mode = 1'b0; count = 4'd0; clr_err = 1'b0;
    #10;
    checks++;
    if ({locked, mismatch, expected, err_count, sticky_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got l=%0b m=%0b e=%0d c=%0d s=%0b want all 0",
               locked, mismatch, expected, err_count, sticky_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_even_lock;
    logic [3:0] seq [10] = '{0, 2, 4, 6, 8, 10, 12, 14, 0, 2};
    step(1'b1, 1'b0, seq[0]);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL even_first_unlocked got %0b want 0", locked);
    end
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 1'b0, seq[i]);
      checks++;
      if (locked !== 1'b1 || mismatch !== 1'b0) begin
        errors++;
        $display("FAIL even_track[%0d] locked=%0b mismatch=%0b want 1/0",
                 i, locked, mismatch);
      end
      if (i == 7) begin
        checks++;
        if (expected !== 4'd0) begin
          errors++;
          $display("FAIL even_wrap got %0d want 0", expected);
        end
      end
    end
    checks++;
    if (expected !== 4'd4 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL even_end exp=%0d err=%0d want 4/0", expected, err_count);
    end
  endtask

  task automatic test_odd;
    step(1'b1, 1'b1, 4'd1);
    checks++;
    if (locked !== 1'b0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL odd_first locked=%0b mismatch=%0b want 0/0",
               locked, mismatch);
    end
    step(1'b1, 1'b1, 4'd3);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL odd_lock got %0b want 1", locked);
    end
    step(1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b1, 4'd7);
    checks++;
    if (expected !== 4'd9 || sticky_err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL odd_end exp=%0d sticky=%0b err=%0d want 9/0/0",
               expected, sticky_err, err_count);
    end
  endtask

  task automatic test_injected_error;
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd2);
    step(1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 4'd6);
    checks++;
    if (mismatch !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL inj_pre mismatch=%0b locked=%0b want 0/1",
               mismatch, locked);
    end
    step(1'b1, 1'b0, 4'd9);
    checks++;
    if (mismatch !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 ||
        sticky_err !== 1'b1) begin
      errors++;
      $display("FAIL inj_hit mis=%0b lock=%0b err=%0d st=%0b want 1/0/1/1",
               mismatch, locked, err_count, sticky_err);
    end
    step(1'b1, 1'b0, 4'd12);
    checks++;
    if (mismatch !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL inj_pulse mis=%0b lock=%0b want 0/0", mismatch, locked);
    end
    step(1'b1, 1'b0, 4'd14);
    checks++;
    if (locked !== 1'b1 || expected !== 4'd0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL inj_relock lock=%0b exp=%0d err=%0d want 1/0/1",
               locked, expected, err_count);
    end
  endtask

  task automatic test_mode_switch;
    logic [3:0] seq [5] = '{0, 2, 4, 6, 8};
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, seq[i]);
    checks++;
    if (locked !== 1'b1 || expected !== 4'd10) begin
      errors++;
      $display("FAIL sw_pre lock=%0b exp=%0d want 1/10", locked, expected);
    end
    step(1'b1, 1'b1, 4'd1);
    checks++;
    if (mismatch !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL sw_first mis=%0b lock=%0b want 0/0", mismatch, locked);
    end
    step(1'b1, 1'b1, 4'd3);
    checks++;
    if (locked !== 1'b1 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL sw_lock lock=%0b mis=%0b want 1/0", locked, mismatch);
    end
    step(1'b1, 1'b1, 4'd5);
    checks++;
    if (err_count !== 8'd1 || expected !== 4'd7) begin
      errors++;
      $display("FAIL sw_end err=%0d exp=%0d want 1/7", err_count, expected);
    end
  endtask

  task automatic test_clear;
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd2);
    clr_err = 1'b1;
    step(1'b1, 1'b0, 4'd8);
    clr_err = 1'b0;
    checks++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || sticky_err !== 1'b1) begin
      errors++;
      $display("FAIL clr_coinc mis=%0b err=%0d st=%0b want 1/1/1",
               mismatch, err_count, sticky_err);
    end
    clr_err = 1'b1;
    step(1'b0, 1'b0, 4'd3);
    clr_err = 1'b0;
    checks++;
    if (err_count !== 8'd0 || sticky_err !== 1'b0 || expected !== 4'd10) begin
      errors++;
      $display("FAIL clr_only err=%0d st=%0b exp=%0d want 0/0/10",
               err_count, sticky_err, expected);
    end
  endtask

  task automatic test_enable_hold;
    step(1'b1, 1'b0, 4'd10);
    checks++;
    if (locked !== 1'b1 || expected !== 4'd12) begin
      errors++;
      $display("FAIL en_pre lock=%0b exp=%0d want 1/12", locked, expected);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'd5 + 4'(i));
      checks++;
      if (locked !== 1'b1 || expected !== 4'd12 || mismatch !== 1'b0 ||
          err_count !== 8'd0) begin
        errors++;
        $display("FAIL en_hold[%0d] lock=%0b exp=%0d mis=%0b err=%0d",
                 i, locked, expected, mismatch, err_count);
      end
    end
    step(1'b1, 1'b0, 4'd12);
    checks++;
    if (locked !== 1'b1 || mismatch !== 1'b0 || expected !== 4'd14) begin
      errors++;
      $display("FAIL en_resume lock=%0b mis=%0b exp=%0d want 1/0/14",
               locked, mismatch, expected);
    end
  endtask

  task automatic test_saturation;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'd8);
      checks++;
      if (mismatch2 !== 1'b1) begin
        errors++;
        $display("FAIL sat_pulse[%0d] got %0b want 1", i, mismatch2);
      end
      step(1'b1, 1'b0, 4'd10);
    end
    checks++;
    if (err_count2 !== 2'd3 || sticky_err2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_small err=%0d st=%0b want 3/1", err_count2, sticky_err2);
    end
    checks++;
    if (err_count !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide err=%0d want 5", err_count);
    end
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd8);
      step(1'b1, 1'b0, 4'd10);
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd3 || expected !== 4'd12) begin
      errors++;
      $display("FAIL ar_pre lock=%0b err=%0d exp=%0d want 1/3/12",
               locked, err_count, expected);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({locked, mismatch, expected, err_count, sticky_err} !== 15'd0) begin
      errors++;
      $display("FAIL ar_clear got l=%0b m=%0b e=%0d c=%0d s=%0b want all 0",
               locked, mismatch, expected, err_count, sticky_err);
    end
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_even_lock();
    test_odd();
    test_injected_error();
    test_mode_switch();
    test_clear();
    test_enable_hold();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/evenodd_count_checker.md
Name: evenodd_count_checker

Overview:
- Receive-side monitor for the even/odd counter stream (mode + count bus).
- Samples the counter output on each enabled clock edge.
- Locks onto the even (mode=0) or odd (mode=1) sequence, predicts each next value and flags deviations.
- Keeps a saturating error count and a sticky error flag, used in benches and on-chip self-check.

Parameters:
- WIDTH, 4, width of the observed count bus.
- ERR_CNT_W, 8, width of the saturating error counter.
- LOCK_LEN, 2, consecutive in-sequence samples required to lock (legal range 1 to 15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  sample enable; a sample is taken on a rising clk edge with en=1.
- mode  input  1  0 = even sequence (0,2,..,14,0), 1 = odd sequence (1,3,..,15,1).
- count  input  WIDTH  observed counter value.
- clr_err  input  1  synchronous clear of err_count and sticky_err.
- locked  output  1  1 while in TRACK.
- mismatch  output  1  one-cycle pulse on a detected sequence error.
- expected  output  WIDTH  predicted value of the next sample.
- err_count  output  ERR_CNT_W  number of mismatches, saturating at all-ones.
- sticky_err  output  1  set by any mismatch; held until clr_err or rst.

Behaviour:
- All outputs are registered and reflect a sample one cycle after the sampling edge.
- Reset (async, any time, including mid-track):
  - state=ACQ, locked=0, mismatch=0, expected=0, err_count=0, sticky_err=0.
  - Internal streak=0, mode_q=0.
- Parity-valid sample: count[0] == mode.
- Next prediction: expected <= count + 2, modulo 2^WIDTH. Wrap is legal, e.g. 14 -> 0 and 15 -> 1 at WIDTH=4.
- mode_q captures mode on every sample.
- en=0: all state, expected and counters hold; mismatch=0.
- ACQ state (locked=0), on each sample:
  - streak>0, count==expected and mode==mode_q: streak++ and expected updated.
  - Otherwise (restart): if parity valid, streak=1 and expected updated; if not, streak=0 and expected holds.
  - When streak reaches LOCK_LEN, go to TRACK and set locked=1 in the same update. With LOCK_LEN=1, the first parity-valid sample locks.
  - A mismatch in ACQ never raises mismatch and never increments err_count.
- TRACK state, on each sample:
  - mode != mode_q (mode switch): legitimate, not an error. Go to ACQ, locked=0, then restart acquisition on this sample as above.
  - count == expected: stay in TRACK, expected updated.
  - count != expected:
    - mismatch=1 for one cycle.
    - err_count++ (saturating); sticky_err=1.
    - Go to ACQ, locked=0, then restart acquisition on this sample.
- clr_err:
  - Clears err_count and sticky_err on the next edge.
  - If it coincides with a mismatch, the clear applies first, then the increment: err_count=1, sticky_err=1.
  - Has no effect on state, locked or expected.
- Saturation: err_count at all-ones stays at all-ones; mismatch still pulses.
- Upstream counter reset mid-stream (count jumps to 0 or 1) while locked is a mismatch, unless mode also changed.
- Ports and state use only the clk/rst domain; no combinational input-to-output paths.

Test Plan:
- Even lock and wrap:
  - Stimulus: rst high 10 ns, then mode=0, en=1, count 0,2,4,..,14,0,2.
  - Required: locked=1 after the 2nd sample; expected=0 after the sample 14; no mismatch; err_count=0.
- Odd sequence:
  - Stimulus: mode=1, count 1,3,5,7.
  - Required: locked after sample 3; expected=9 after sample 7; sticky_err=0.
- Injected error:
  - Stimulus: locked on even, feed 4,6,9,12,14.
  - Required: mismatch pulses once, one cycle after sample 9; locked drops; err_count=1, sticky_err=1; relock after 12,14 with expected=0.
- Mode switch:
  - Stimulus: locked at 8 in mode=0, then mode=1 with count 1,3,5.
  - Required: no mismatch; locked=0 after sample 1; locked=1 after sample 3; err_count unchanged.
- Reset and clear:
  - Assert rst asynchronously between edges while locked with err_count=3. Required: all outputs zero immediately.
  - Assert clr_err coincident with a mismatch. Required: err_count=1.
- Saturation and enable:
  - Stimulus: ERR_CNT_W=2, force 5 mismatches. Required: err_count stays 3.
  - Stimulus: en=0 for 3 cycles with garbage count. Required: no state change.
